// File: rtl/lfsr_delay_ctrl.sv
// Single-slot request stager that inserts random, fixed or zero wait states
// between an upstream requester and a downstream consumer, counting stalls.
module lfsr_delay_ctrl #(
    parameter int DW   = 32,
    parameter int DLYW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      lfsr,
    input  logic [1:0]      cfg_mode,
    input  logic [DLYW-1:0] cfg_delay,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            busy,
    output logic [15:0]     stall_cnt,
    input  logic            cnt_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RANDOM = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;

    state_t          state, state_nxt;
    logic [DLYW-1:0] cnt, cnt_nxt;
    logic [DLYW-1:0] dly;
    logic [DW-1:0]   data_q;
    logic [15:0]     stall_q;
    logic            accept;
    logic            lfsr_unused;

    // Bits of the random source above DLYW never reach the delay.
    assign lfsr_unused = ^lfsr;

    assign accept = (state == IDLE) && in_valid;

    // Mode 11 is reserved and behaves like zero-delay.
    always_comb begin
        case (cfg_mode)
            MODE_RANDOM: dly = lfsr[DLYW-1:0];
            MODE_FIXED:  dly = cfg_delay;
            default:     dly = '0;
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (dly == '0) begin
                        state_nxt = SEND;
                    end else begin
                        cnt_nxt   = dly;
                        state_nxt = DELAY;
                    end
                end
            end
            DELAY: begin
                cnt_nxt = cnt - DLYW'(1);
                if (cnt == DLYW'(1)) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The payload register is cleared on reset so out_data reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (accept) begin
            data_q <= in_data;
        end
    end

    // Clear wins over increment; the count saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_q <= '0;
        end else if ((state == DELAY) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign out_data  = data_q;
    assign stall_cnt = stall_q;

endmodule
